// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control-field layout and bubble encodings for pipeline stage registers
package pipe_pkg;

    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        STG_IF_ID  = 2'd0,
        STG_ID_EX  = 2'd1,
        STG_EX_MEM = 2'd2,
        STG_MEM_WB = 2'd3
    } stage_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'd0,
        ALUOP_BRANCH = 2'd1,
        ALUOP_RTYPE  = 2'd2,
        ALUOP_ITYPE  = 2'd3
    } alu_op_e;

    // Packed layout, MSB first: reg_write is bit 15, funct7 occupies bits 1:0
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        op_a_sel_e  op_a_sel;
        logic       alu_src;
        alu_op_e    alu_op;
        logic [2:0] funct3;
        logic [1:0] funct7;
    } ctrl_t;

    // All-zero control never writes a register or memory, so it is safe everywhere
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_IF_ID  = '0;
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_ID_EX  = '0;
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_EX_MEM = '0;
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_MEM_WB = '0;

    function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(input ctrl_t c);
        return c;
    endfunction

    function automatic ctrl_t unpack_ctrl(input logic [CTRL_W_DEF-1:0] v);
        return ctrl_t'(v);
    endfunction

    function automatic logic [CTRL_W_DEF-1:0] bubble_for(input stage_e s);
        return s == STG_IF_ID  ? BUBBLE_IF_ID  :
               s == STG_ID_EX  ? BUBBLE_ID_EX  :
               s == STG_EX_MEM ? BUBBLE_EX_MEM : BUBBLE_MEM_WB;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_slot.sv
// pipe_skid_slot: one valid+ctrl+data holding slot with load and clear
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Clear wins over load and parks ctrl at the bubble value; data is left as is
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            ctrl  <= CTRL_BUBBLE;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry and flush
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                SKID        = 1,
    parameter int                CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    logic              main_v, skid_v;
    logic              accept, consume;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic [CTRL_W-1:0] skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] skid_data, main_d_data;
    logic [1:0]        drop;
    logic [CNT_W:0]    cnt_sum;

    // Handshake decode: the head refills from skid first so ordering stays FIFO
    always_comb begin
        in_ready    = (SKID != 0 ? !skid_v : (!main_v | out_ready)) & !flush;
        accept      = in_valid & in_ready;
        consume     = main_v & out_ready;
        main_load   = (skid_v & consume) | (accept & (!main_v | consume));
        main_clear  = flush | (consume & !main_load);
        skid_load   = (SKID != 0) & accept & main_v & !consume;
        skid_clear  = flush | (skid_v & consume);
        main_d_ctrl = skid_v ? skid_ctrl : in_ctrl;
        main_d_data = skid_v ? skid_data : in_data;
        drop        = {1'b0, main_v & !out_ready} + {1'b0, skid_v};
        cnt_sum     = {1'b0, drop_count} + (CNT_W + 1)'(drop);
    end

    pipe_skid_slot #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (main_load),
        .clear   (main_clear),
        .d_ctrl  (main_d_ctrl),
        .d_data  (main_d_data),
        .valid   (main_v),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    pipe_skid_slot #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .valid   (skid_v),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    assign out_valid = main_v;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    // Count entries killed by flush that downstream did not take, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!reset_n)
            drop_count <= '0;
        else if (flush)
            drop_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the stage register in skid and single-entry builds
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 32;
    localparam logic [CW-1:0] S0_BUBBLE = 16'h0F00;

    logic          clk = 1'b0;
    logic          reset_n, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [7:0]    drop_count;

    logic          s0_in_ready, s0_out_valid;
    logic [CW-1:0] s0_out_ctrl;
    logic [DW-1:0] s0_out_data;
    logic [1:0]    s0_occupancy;
    logic [7:0]    s0_drop_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(S0_BUBBLE), .SKID(0), .CNT_W(8)) u_s0 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_ctrl(s0_out_ctrl), .out_data(s0_out_data),
        .occupancy(s0_occupancy), .drop_count(s0_drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'h1234, 32'hDEAD);
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_drop", drop_count, 0);
        reset_n = 1'b1;
        drive(1'b0, 0, 0);
        #1;
        chk("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'h0010 + 16'(i), 32'(i));
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 64'(i));
            chk("stream_ctrl", out_ctrl, 64'(16'h0010 + 16'(i)));
            chk("stream_occ", occupancy, 1);
        end
        drive(1'b0, 0, 0);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_ctrl", out_ctrl, 0);
        chk("drain_occ", occupancy, 0);

        out_ready = 1'b0;
        drive(1'b1, 16'h002A, 32'hA);
        tick();
        chk("stall_a_occ", occupancy, 1);
        chk("stall_a_rdy", in_ready, 1);
        drive(1'b1, 16'h002B, 32'hB);
        tick();
        drive(1'b0, 0, 0);
        #1;
        chk("stall_occ2", occupancy, 2);
        chk("stall_rdy0", in_ready, 0);
        chk("stall_head_data", out_data, 32'hA);
        chk("stall_head_ctrl", out_ctrl, 16'h002A);
        out_ready = 1'b1;
        #1;
        chk("stall_rdy_pre", in_ready, 0);
        tick();
        chk("rel_b_data", out_data, 32'hB);
        chk("rel_b_ctrl", out_ctrl, 16'h002B);
        chk("rel_b_occ", occupancy, 1);
        chk("rel_b_rdy", in_ready, 1);
        tick();
        chk("rel_end_valid", out_valid, 0);
        chk("rel_end_occ", occupancy, 0);

        out_ready = 1'b0;
        drive(1'b1, 16'h0031, 32'h31);
        tick();
        drive(1'b1, 16'h0032, 32'h32);
        tick();
        drive(1'b0, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush_rdy", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_drop2", drop_count, 2);
        chk("flush_data_hold", out_data, 32'h31);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_again_drop", drop_count, 2);

        out_ready = 1'b1;
        drive(1'b1, 16'h0041, 32'h41);
        tick();
        chk("fr_pre_occ", occupancy, 1);
        drive(1'b1, 16'h0042, 32'h42);
        flush = 1'b1;
        #1;
        chk("fr_rdy0", in_ready, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 0, 0);
        chk("fr_drop", drop_count, 2);
        chk("fr_occ", occupancy, 0);
        chk("fr_valid", out_valid, 0);
        tick();
        chk("fr_no_accept", occupancy, 0);

        out_ready = 1'b0;
        for (int k = 0; k < 126; k++) begin
            drive(1'b1, 16'h0050, 32'(k));
            tick();
            tick();
            drive(1'b0, 0, 0);
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        chk("sat_254", drop_count, 254);
        drive(1'b1, 16'h0051, 32'h51);
        tick();
        drive(1'b0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat_255", drop_count, 255);
        drive(1'b1, 16'h0052, 32'h52);
        tick();
        tick();
        drive(1'b0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat_hold", drop_count, 255);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("s0_rst_ctrl", s0_out_ctrl, S0_BUBBLE);
        chk("s0_rst_occ", s0_occupancy, 0);
        chk("s0_rst_rdy", s0_in_ready, 1);
        drive(1'b1, 16'h0061, 32'h61);
        tick();
        drive(1'b1, 16'h0062, 32'h62);
        #1;
        chk("s0_full_rdy0", s0_in_ready, 0);
        chk("s0_full_occ", s0_occupancy, 1);
        tick();
        chk("s0_hold_data", s0_out_data, 32'h61);
        chk("s0_hold_ctrl", s0_out_ctrl, 16'h0061);
        out_ready = 1'b1;
        #1;
        chk("s0_comb_rdy1", s0_in_ready, 1);
        tick();
        chk("s0_swap_data", s0_out_data, 32'h62);
        chk("s0_swap_occ", s0_occupancy, 1);
        chk("s0_swap_valid", s0_out_valid, 1);
        drive(1'b0, 0, 0);
        tick();
        chk("s0_drain_valid", s0_out_valid, 0);
        chk("s0_drain_ctrl", s0_out_ctrl, S0_BUBBLE);
        out_ready = 1'b0;
        drive(1'b1, 16'h0063, 32'h63);
        tick();
        drive(1'b0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s0_flush_drop", s0_drop_count, 1);
        chk("s0_flush_ctrl", s0_out_ctrl, S0_BUBBLE);
        chk("s0_flush_valid", s0_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers. It carries any control/data split between two pipeline stages.
- Adds a valid/ready handshake with an optional 2-entry skid buffer, so stalls propagate without combinational ready paths.
- Flush inserts a bubble: it clears valid and forces control to a safe value.
- It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB in place of hand-written registers.

Parameters:
- CTRL_W, 16: width of control field; forced to CTRL_BUBBLE on flush/reset.
- DATA_W, 128: width of data payload; not cleared on flush, don't-care when invalid.
- CTRL_BUBBLE, {CTRL_W{1'b0}}: control value presented when out_valid=0.
- SKID, 1: 1 = 2-entry skid (registered in_ready); 0 = single entry (in_ready combinational from out_ready).
- CNT_W, 8: width of saturating flush-drop counter.

Ports:
- clk in 1: clock, rising edge.
- reset_n in 1: synchronous, active-low reset.
- flush in 1: discard all held entries this edge.
- in_valid in 1: upstream entry valid.
- in_ready out 1: stage can accept.
- in_ctrl in CTRL_W: upstream control.
- in_data in DATA_W: upstream data.
- out_valid out 1: entry presented downstream.
- out_ready in 1: downstream accepts.
- out_ctrl out CTRL_W: control of head entry, CTRL_BUBBLE when !out_valid.
- out_data out DATA_W: data of head entry.
- occupancy out 2: entries held, 0..2 (0..1 when SKID=0).
- drop_count out CNT_W: valid entries discarded by flush, saturating.

Behaviour:
- Storage:
  - Main register (head, drives out_*) plus skid register when SKID=1.
  - Valid bits main_v and skid_v.
  - All outputs are registered except in_ready in SKID=0.
- Reset (reset_n=0 at edge):
  - main_v=skid_v=0; out_ctrl=CTRL_BUBBLE; out_data=0; drop_count=0.
  - Reset dominates flush and all handshakes.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
  - out_valid=main_v.
  - Upstream must hold in_ctrl/in_data stable while in_valid & !in_ready.
- in_ready:
  - SKID=1: in_ready = !skid_v & !flush. skid_v is registered; flush gating is the only combinational term.
  - SKID=0: in_ready = (!main_v | out_ready) & !flush.
- SKID=1 state transitions, per edge, no flush (state = occupancy):
  - 0, accept → main←in, occ 1.
  - 1, release & accept → main←in, occ 1.
  - 1, release, no accept → occ 0.
  - 1, no release, accept → skid←in, occ 2.
  - 1, neither → hold.
  - 2, release → main←skid, skid_v=0, occ 1. No accept is possible because in_ready=0.
  - 2, no release → hold.
- Ordering: strict FIFO; an entry never overtakes the skid entry.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1/cycle with out_ready=1.
- Flush:
  - At the edge: main_v=skid_v=0, out_ctrl=CTRL_BUBBLE, data registers hold.
  - A release occurring in the flush cycle still counts as consumed by downstream.
  - No accept in the flush cycle.
  - drop_count += number of valid entries not released that cycle (0, 1 or 2), saturating at 2^CNT_W-1.
- out_ctrl:
  - Loaded with CTRL_BUBBLE whenever main_v becomes 0 (release without refill, flush, reset).
  - Held constant while out_valid & !out_ready.
- Back-to-back flush: second flush on empty stage is a no-op and adds 0 to drop_count.

Decomposition:
- Shared package pipe_pkg holds:
  - Default widths.
  - CTRL_BUBBLE encodings per stage.
  - Packed control-field layout: RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump, op_a_sel[1:0], ALUSrc, ALUOp[1:0], funct3, funct7 positions.
- Stages pack and unpack control via package helpers.
- One natural sub-module, pipe_skid_slot: single valid+ctrl+data slot with load/clear. It is instantiated for main and skid.
- Counter and FSM logic stay in the top.

Test Plan:
- Reset: reset_n=0 with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, drop_count=0, in_ready=1 (SKID=1).
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later, no gaps, occupancy=1.
- Stall: feed A,B with out_ready=0.
  - A is in main, B is in skid; occupancy=2, in_ready=0.
  - Raise out_ready → A then B released in order; in_ready=1 one cycle after A released.
- Flush with occupancy=2, out_ready=0 → next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, drop_count=2.
  - Repeat flush → drop_count stays 2.
  - Saturation: preload to 255 with CNT_W=8 → stays 255.
- Flush in same cycle as release with occupancy=1 and out_ready=1 → drop_count unchanged, in_ready=0 that cycle, in_valid entry not accepted.
- SKID=0 build: out_ready=0, main full → in_ready=0 combinationally. Raise out_ready with in_valid=1 → simultaneous release and accept, occupancy stays 1.
